mem_ctrl_stage: RTL
===================

# mem_ctrl_stage

Sequential successor to the combinational MEM stage: executes RISC-V loads and stores over a byte-wide, arbitrated RAM port as a multi-cycle transaction. It stalls the pipeline while a transfer is in flight, then presents a registered write-back result to MEM/WB. Address width and RAM read latency are parameters. Sign and zero extension for LB/LH/LBU/LHU are performed here, not in WB.

## Interface
- ADDR_W, default 32, width of `mem_a_o`; byte address, wraps modulo 2^ADDR_W.
- MEM_LAT, default 1, legal 1..3, cycles from address issue to valid `mem_din_i`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- aluop_i  in  `AluOpBus  operation; EXE_{LB,LH,LW,LBU,LHU,SB,SH,SW}_OP are memory ops, anything else passes through.
- rd_i / wreg_i / wdata_i  in  `RegAddrBus / 1 / `RegBus  destination, write enable, ALU result.
- mem_addr_i  in  `RegBus  effective address; the low ADDR_W bits are used.
- mem_reg2_i  in  `RegBus  store data (rs2).
- mem_req_o  out  1  request to the RAM arbiter.
- mem_gnt_i  in  1  grant; the arbiter holds it until `mem_req_o` falls.
- mem_a_o  out  ADDR_W  byte address.
- mem_wr_o  out  1  1 = write byte.
- mem_dout_o  out  8  write byte.
- mem_din_i  in  8  read byte.
- stall_req_o  out  1  holds IF/ID/EX and EX/MEM.
- wb_valid_o / rd_o / wreg_o / wdata_o  out  1 / `RegAddrBus / 1 / `RegBus  registered result to MEM/WB.

## Operation
- States: IDLE, REQ, XFER, DONE.
- **IDLE**
  - `valid_i` with a non-memory op: register rd/wreg/wdata; `wb_valid_o` = 1 next cycle; no stall.
  - `valid_i` with a memory op: latch op, address, rs2, rd and wreg; go to REQ.
  - `stall_req_o` is asserted combinationally in this same cycle.
- **REQ**: `mem_req_o` = 1; on `mem_gnt_i` = 1 go to XFER.
- **XFER**
  - N = 1/2/4 bytes for byte/half/word ops.
  - Issue counter k runs 0..N-1; `mem_a_o` = base + k.
  - Stores: `mem_wr_o` = 1, `mem_dout_o` = rs2 byte k (little-endian).
  - Loads: `mem_wr_o` = 0. A MEM_LAT-deep valid/index shift line marks the returning bytes; byte k is captured into result byte k.
  - Transition to DONE:
    - stores: after the last byte is issued;
    - loads: after the last byte is captured.
  - After issue completes and before capture completes, `mem_a_o` holds its last value and `mem_wr_o` = 0.
- **DONE** (1 cycle)
  - `mem_req_o` = 0 and `stall_req_o` = 0.
  - `wb_valid_o` = 1 with the final rd/wreg/wdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses all 4 bytes.
  - Stores and x0 destinations: `wreg_o` = 0 for stores; a load to x0 keeps its `wreg_o` value and the register file ignores the write.
  - Next state is IDLE; a new instruction is accepted from the following cycle.
- Misaligned addresses are legal (byte-serial access). Address wrap at 2^ADDR_W is silent.
- `mem_gnt_i` falling during XFER is a protocol violation; behaviour is undefined, and the bench asserts it never happens.

## Timing
- Reset (synchronous): state IDLE, all outputs 0, counters and shift line cleared. Reset mid-transaction abandons it; no further `mem_wr_o`.
- Accept cycle T, grant already high:
  - REQ at T+1, XFER from T+2.
  - Store: DONE at T+2+N.
  - Load: DONE at T+2+N+MEM_LAT.
  - Example: LW with MEM_LAT = 1 gives DONE at T+7.
- Grant delayed by G cycles: add G.
- Pass-through op: result at T+1.
- `stall_req_o` is high from T through the cycle before DONE.
- `wb_valid_o` is a one-cycle pulse.

## Structure
- Op codes and `AluOpBus`/`RegBus`/`RegAddrBus` stay in the shared defines file.
- Add to the shared defines file: state encodings (MEM_ST_IDLE..MEM_ST_DONE), MEM_BYTE/HALF/WORD sizes, and a byte-count function.
- One sub-module, `mem_rd_tracker`, holds the MEM_LAT-deep shift line of {valid, byte index}. It outputs the capture strobe and index.

## Test plan
- LW at 0x1000, RAM bytes 0x11,0x22,0x33,0x44, MEM_LAT = 1, grant immediate -> DONE at T+7, `wdata_o` = 0x44332211, stall high T..T+6.
- LB at 0x2003 holding 0x80 -> `wdata_o` = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH rs2 = 0xDEADBEEF at 0x3001 -> byte writes 0xEF@0x3001 then 0xBE@0x3002, `wreg_o` = 0, DONE at T+4.
- Grant withheld 5 cycles, MEM_LAT = 3, LH at 0x4000 holding 0xFF,0x7F -> DONE at T+12, `wdata_o` = 0x00007FFF.
- Reset asserted during XFER of SW -> next cycle: IDLE, `mem_req_o` = 0, `mem_wr_o` = 0, no further writes.
- ADD passthrough (rd = 5, wdata = 0x7) followed by SB -> `wb_valid_o` at T+1 with no stall; SB accepted at T+1.

Source files
------------

// File: rtl/mem_ctrl_stage_pkg.sv
// mem_ctrl_stage_pkg: shared op codes, bus types, FSM states and access-size helpers
package mem_ctrl_stage_pkg;
  typedef logic [7:0] alu_op_t;
  typedef logic [31:0] reg_t;
  typedef logic [4:0] reg_addr_t;
  localparam alu_op_t EXE_ADD_OP = 8'b00100000;
  localparam alu_op_t EXE_LB_OP = 8'b11100000;
  localparam alu_op_t EXE_LH_OP = 8'b11100001;
  localparam alu_op_t EXE_LW_OP = 8'b11100011;
  localparam alu_op_t EXE_LBU_OP = 8'b11100100;
  localparam alu_op_t EXE_LHU_OP = 8'b11100101;
  localparam alu_op_t EXE_SB_OP = 8'b11101000;
  localparam alu_op_t EXE_SH_OP = 8'b11101001;
  localparam alu_op_t EXE_SW_OP = 8'b11101011;
  typedef enum logic [1:0] {MEM_ST_IDLE, MEM_ST_REQ, MEM_ST_XFER, MEM_ST_DONE} mem_st_e;
  localparam logic [2:0] MEM_BYTE = 3'd1;
  localparam logic [2:0] MEM_HALF = 3'd2;
  localparam logic [2:0] MEM_WORD = 3'd4;
  function automatic logic is_load(alu_op_t op);
    return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
  endfunction
  function automatic logic is_store(alu_op_t op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_mem(alu_op_t op);
    return is_load(op) || is_store(op);
  endfunction
  function automatic logic [2:0] mem_nbytes(alu_op_t op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP} ? MEM_BYTE :
           op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP} ? MEM_HALF :
           op inside {EXE_LW_OP, EXE_SW_OP} ? MEM_WORD : 3'd0;
  endfunction
endpackage

// File: rtl/mem_ctrl_stage_rd_tracker.sv
// mem_rd_tracker: MEM_LAT-deep {valid, byte index} line marking returning read bytes
module mem_rd_tracker #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [1:0] idx,
  output logic       cap,
  output logic [1:0] cap_idx
);
  logic [MEM_LAT-1:0] v;
  logic [1:0] ix [MEM_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < MEM_LAT; i++) ix[i] <= 2'd0;
    end else begin
      v[0] <= issue;
      ix[0] <= idx;
      for (int i = 1; i < MEM_LAT; i++) begin
        v[i] <= v[i-1];
        ix[i] <= ix[i-1];
      end
    end
  end
  assign cap = v[MEM_LAT-1];
  assign cap_idx = ix[MEM_LAT-1];
endmodule

// File: rtl/mem_ctrl_stage.sv
// mem_ctrl_stage: byte-serial multi-cycle load/store stage with registered write-back
module mem_ctrl_stage
  import mem_ctrl_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  alu_op_t           aluop_i,
  input  reg_addr_t         rd_i,
  input  logic              wreg_i,
  input  reg_t              wdata_i,
  input  reg_t              mem_addr_i,
  input  reg_t              mem_reg2_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  output logic              stall_req_o,
  output logic              wb_valid_o,
  output reg_addr_t         rd_o,
  output logic              wreg_o,
  output reg_t              wdata_o
);
  mem_st_e st;
  alu_op_t op;
  logic [ADDR_W-1:0] base;
  reg_t rs2, res, full, ext;
  reg_addr_t rd;
  logic wreg, ld, issuing, cap, last;
  logic [2:0] n, k, got;
  logic [1:0] cap_idx;
  mem_rd_tracker #(.MEM_LAT(MEM_LAT)) u_trk (
    .clk(clk), .rst(rst), .issue(issuing && ld), .idx(k[1:0]), .cap(cap), .cap_idx(cap_idx)
  );
  // full folds in the byte arriving this cycle so the last capture can retire immediately
  always_comb begin
    n = mem_nbytes(op);
    ld = is_load(op);
    issuing = st == MEM_ST_XFER && k < n;
    full = res;
    if (cap) full[{cap_idx, 3'b000} +: 8] = mem_din_i;
    ext = op == EXE_LB_OP ? {{24{full[7]}}, full[7:0]} :
          op == EXE_LBU_OP ? {24'd0, full[7:0]} :
          op == EXE_LH_OP ? {{16{full[15]}}, full[15:0]} :
          op == EXE_LHU_OP ? {16'd0, full[15:0]} : full;
    last = ld ? cap && got == n - 3'd1 : issuing && k == n - 3'd1;
  end
  assign mem_req_o = st == MEM_ST_REQ || st == MEM_ST_XFER;
  assign mem_wr_o = issuing && !ld;
  assign mem_a_o = st == MEM_ST_XFER ? base + ADDR_W'(issuing ? k : k - 3'd1) : base;
  assign mem_dout_o = mem_wr_o ? rs2[{k[1:0], 3'b000} +: 8] : 8'h00;
  assign stall_req_o = mem_req_o || (st == MEM_ST_IDLE && valid_i && is_mem(aluop_i));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= MEM_ST_IDLE;
      op <= '0;
      base <= '0;
      rs2 <= '0;
      res <= '0;
      rd <= '0;
      wreg <= 1'b0;
      k <= '0;
      got <= '0;
      wb_valid_o <= 1'b0;
      rd_o <= '0;
      wreg_o <= 1'b0;
      wdata_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      case (st)
        MEM_ST_IDLE:
          if (valid_i && is_mem(aluop_i)) begin
            op <= aluop_i;
            base <= mem_addr_i[ADDR_W-1:0];
            rs2 <= mem_reg2_i;
            rd <= rd_i;
            wreg <= wreg_i;
            res <= '0;
            k <= '0;
            got <= '0;
            st <= MEM_ST_REQ;
          end else if (valid_i) begin
            wb_valid_o <= 1'b1;
            rd_o <= rd_i;
            wreg_o <= wreg_i;
            wdata_o <= wdata_i;
          end
        MEM_ST_REQ: st <= mem_gnt_i ? MEM_ST_XFER : MEM_ST_REQ;
        MEM_ST_XFER: begin
          res <= full;
          k <= issuing ? k + 3'd1 : k;
          got <= cap ? got + 3'd1 : got;
          if (last) begin
            st <= MEM_ST_DONE;
            wb_valid_o <= 1'b1;
            rd_o <= rd;
            wreg_o <= wreg && ld;
            wdata_o <= ext;
          end
        end
        MEM_ST_DONE: st <= MEM_ST_IDLE;
      endcase
    end
  end
endmodule
